// File: rtl/sram_mem_responder.sv
// Processor-side memory responder: serves one data access then one instruction
// fetch per processor cycle from a single asynchronous 32-bit SRAM, stalling until done.
module sram_mem_responder #(
  parameter int ADDR_W = 18,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       inst,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        bwe,
  input  logic              data_rd,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {
    IDLE,
    DRD,
    DWR,
    DWR_REC,
    IFETCH,
    RESP
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_CYC - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYC - 1);

  state_t state, next_state;
  logic [3:0] wait_cnt, wait_cnt_nxt;

  logic [ADDR_W-1:0] req_iw, req_dw, req_iw_nxt, req_dw_nxt;
  logic [31:0]       req_wdata, req_wdata_nxt;
  logic [3:0]        req_bwe, req_bwe_nxt;

  logic              stall_nxt;
  logic [ADDR_W-1:0] sram_addr_nxt;
  logic [31:0]       sram_dq_o_nxt;
  logic              sram_dq_oe_nxt;
  logic              sram_ce_n_nxt;
  logic              sram_oe_n_nxt;
  logic              sram_we_n_nxt;
  logic [3:0]        sram_be_n_nxt;

  // Byte-address bits outside the SRAM word range alias and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                              data_addr[31:ADDR_W+2], data_addr[1:0]};

  // Next state, next request registers, and the pin pattern of the state being entered,
  // so every SRAM pin is a flop that already shows the new state's values at entry.
  always_comb begin
    next_state     = state;
    wait_cnt_nxt   = 4'd0;
    req_iw_nxt     = req_iw;
    req_dw_nxt     = req_dw;
    req_wdata_nxt  = req_wdata;
    req_bwe_nxt    = req_bwe;

    case (state)
      IDLE: begin
        req_iw_nxt    = inst_addr[ADDR_W+1:2];
        req_dw_nxt    = data_addr[ADDR_W+1:2];
        req_wdata_nxt = wdata;
        req_bwe_nxt   = bwe;
        if (bwe != 4'd0)  next_state = DWR;
        else if (data_rd) next_state = DRD;
        else              next_state = IFETCH;
      end
      DRD: begin
        if (wait_cnt == RD_LAST) next_state = IFETCH;
        else                     wait_cnt_nxt = wait_cnt + 4'd1;
      end
      DWR: begin
        if (wait_cnt == WR_LAST) next_state = DWR_REC;
        else                     wait_cnt_nxt = wait_cnt + 4'd1;
      end
      DWR_REC: next_state = IFETCH;
      IFETCH: begin
        if (wait_cnt == RD_LAST) next_state = RESP;
        else                     wait_cnt_nxt = wait_cnt + 4'd1;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    stall_nxt      = (next_state != RESP);
    sram_addr_nxt  = '0;
    sram_dq_o_nxt  = 32'd0;
    sram_dq_oe_nxt = 1'b0;
    sram_ce_n_nxt  = 1'b1;
    sram_oe_n_nxt  = 1'b1;
    sram_we_n_nxt  = 1'b1;
    sram_be_n_nxt  = 4'hF;

    case (next_state)
      DRD: begin
        sram_addr_nxt = req_dw_nxt;
        sram_ce_n_nxt = 1'b0;
        sram_oe_n_nxt = 1'b0;
        sram_be_n_nxt = 4'h0;
      end
      DWR, DWR_REC: begin
        sram_addr_nxt  = req_dw_nxt;
        sram_dq_o_nxt  = req_wdata_nxt;
        sram_dq_oe_nxt = 1'b1;
        sram_ce_n_nxt  = 1'b0;
        sram_we_n_nxt  = (next_state == DWR_REC);
        sram_be_n_nxt  = ~req_bwe_nxt;
      end
      IFETCH: begin
        sram_addr_nxt = req_iw_nxt;
        sram_ce_n_nxt = 1'b0;
        sram_oe_n_nxt = 1'b0;
        sram_be_n_nxt = 4'h0;
      end
      default: ;
    endcase
  end

  // State, request and pin registers; read data is captured on the last read cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      req_iw     <= '0;
      req_dw     <= '0;
      req_wdata  <= 32'd0;
      req_bwe    <= 4'd0;
      stall      <= 1'b1;
      inst       <= 32'd0;
      rdata      <= 32'd0;
      sram_addr  <= '0;
      sram_dq_o  <= 32'd0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      state      <= next_state;
      wait_cnt   <= wait_cnt_nxt;
      req_iw     <= req_iw_nxt;
      req_dw     <= req_dw_nxt;
      req_wdata  <= req_wdata_nxt;
      req_bwe    <= req_bwe_nxt;
      stall      <= stall_nxt;
      sram_addr  <= sram_addr_nxt;
      sram_dq_o  <= sram_dq_o_nxt;
      sram_dq_oe <= sram_dq_oe_nxt;
      sram_ce_n  <= sram_ce_n_nxt;
      sram_oe_n  <= sram_oe_n_nxt;
      sram_we_n  <= sram_we_n_nxt;
      sram_be_n  <= sram_be_n_nxt;
      if (state == DRD && next_state == IFETCH) rdata <= sram_dq_i;
      if (state == IFETCH && next_state == RESP) inst <= sram_dq_i;
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Randomized bench for sram_mem_responder: an async SRAM pin model plus a per-transaction
// timeline model that predicts every pin, stall, inst and rdata value cycle by cycle.
module tb_sram_mem_responder;

  localparam int AW = 18;
  localparam int RD = 2;
  localparam int WR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   inst_addr = 32'd0;
  logic [31:0]   data_addr = 32'd0;
  logic [31:0]   wdata = 32'd0;
  logic [3:0]    bwe = 4'd0;
  logic          data_rd = 1'b0;
  logic [31:0]   inst, rdata;
  logic          stall;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o;
  logic [31:0]   sram_dq_i = 32'hDEADBEEF;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  always #5 clk = ~clk;

  sram_mem_responder #(.ADDR_W(AW), .RD_CYC(RD), .WR_CYC(WR)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst(inst),
    .data_addr(data_addr), .wdata(wdata), .bwe(bwe), .data_rd(data_rd),
    .rdata(rdata), .stall(stall),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  typedef struct packed {
    logic          stall;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic          dq_oe;
    logic [3:0]    be_n;
    logic [AW-1:0] addr;
    logic [31:0]   dq;
    logic [31:0]   inst;
    logic [31:0]   rdata;
  } cyc_t;

  cyc_t        exp_q[$];
  cyc_t        cur;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_inst = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic [31:0] sram_mem[int];
  logic [31:0] ref_mem[int];
  logic        prev_we_n = 1'b1;
  int          pin_a;
  logic [31:0] pin_w;

  function automatic logic [31:0] seed_word(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] sram_get(int a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return seed_word(a);
  endfunction

  function automatic logic [31:0] ref_get(int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return seed_word(a);
  endfunction

  function automatic cyc_t mk(logic st, logic ce, logic oe, logic we, logic dqoe,
                              logic [3:0] be, logic [AW-1:0] ad, logic [31:0] dq,
                              logic [31:0] in, logic [31:0] rd);
    cyc_t c;
    c.stall = st; c.ce_n = ce; c.oe_n = oe; c.we_n = we; c.dq_oe = dqoe;
    c.be_n = be; c.addr = ad; c.dq = dq; c.inst = in; c.rdata = rd;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous SRAM: a write lands when we_n rises while the chip stays selected and
  // data is still driven; reads are presented while ce_n and oe_n are low.
  always @(negedge clk) begin
    if (!prev_we_n && sram_we_n && !sram_ce_n && sram_dq_oe) begin
      pin_a = int'(sram_addr);
      pin_w = sram_get(pin_a);
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) pin_w[8*b +: 8] = sram_dq_o[8*b +: 8];
      sram_mem[pin_a] = pin_w;
    end
    prev_we_n = sram_we_n;
    sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_get(int'(sram_addr)) : 32'hDEADBEEF;
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput("stall", {31'd0, stall}, {31'd0, cur.stall});
      checkOutput("ce_n", {31'd0, sram_ce_n}, {31'd0, cur.ce_n});
      checkOutput("oe_n", {31'd0, sram_oe_n}, {31'd0, cur.oe_n});
      checkOutput("we_n", {31'd0, sram_we_n}, {31'd0, cur.we_n});
      checkOutput("dq_oe", {31'd0, sram_dq_oe}, {31'd0, cur.dq_oe});
      checkOutput("be_n", {28'd0, sram_be_n}, {28'd0, cur.be_n});
      checkOutput("inst", inst, cur.inst);
      checkOutput("rdata", rdata, cur.rdata);
      if (!cur.ce_n) checkOutput("sram_addr", 32'(sram_addr), 32'(cur.addr));
      if (cur.dq_oe) checkOutput("sram_dq_o", sram_dq_o, cur.dq);
    end
  end

  task automatic scramble();
    inst_addr = $urandom;
    data_addr = $urandom;
    wdata     = $urandom;
    bwe       = 4'($urandom);
    data_rd   = 1'($urandom);
  endtask

  // Called at the start of an IDLE cycle; builds the whole expected window, then
  // returns at the start of the following IDLE cycle.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] be, input logic rd);
    logic [AW-1:0] iw, dw;
    logic [31:0]   w, new_inst, new_rdata;
    int            win;
    iw = ia[AW+1:2];
    dw = da[AW+1:2];
    new_rdata = exp_rdata;
    exp_q.push_back(mk(1, 1, 1, 1, 0, 4'hF, '0, 32'd0, exp_inst, exp_rdata));
    if (be != 4'd0) begin
      w = ref_get(int'(dw));
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[int'(dw)] = w;
      repeat (WR) exp_q.push_back(mk(1, 0, 1, 0, 1, ~be, dw, wd, exp_inst, exp_rdata));
      exp_q.push_back(mk(1, 0, 1, 1, 1, ~be, dw, wd, exp_inst, exp_rdata));
    end else if (rd) begin
      new_rdata = ref_get(int'(dw));
      repeat (RD) exp_q.push_back(mk(1, 0, 0, 1, 0, 4'h0, dw, 32'd0, exp_inst, exp_rdata));
    end
    new_inst = ref_get(int'(iw));
    repeat (RD) exp_q.push_back(mk(1, 0, 0, 1, 0, 4'h0, iw, 32'd0, exp_inst, new_rdata));
    exp_q.push_back(mk(0, 1, 1, 1, 0, 4'hF, '0, 32'd0, new_inst, new_rdata));
    win = exp_q.size();
    inst_addr = ia; data_addr = da; wdata = wd; bwe = be; data_rd = rd;
    exp_inst = new_inst;
    exp_rdata = new_rdata;
    for (int k = 1; k <= win; k++) begin
      @(posedge clk); #2;
      if (k < win) scramble();
    end
  endtask

  task automatic resetDuringWrite(input logic [31:0] da, input logic [31:0] wd);
    int dw;
    dw = int'(da[AW+1:2]);
    inst_addr = 32'd0; data_addr = da; wdata = wd; bwe = 4'hF; data_rd = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("rst_pre_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    bwe = 4'd0;
    @(negedge clk);
    checkOutput("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd1);
    checkOutput("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_no_write", sram_get(dw), ref_get(dw));
    @(posedge clk); #2;
    rst = 1'b0;
    exp_inst = 32'd0;
    exp_rdata = 32'd0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 63));
    return a;
  endfunction

  initial begin
    sram_mem[0] = 32'h24010005;     ref_mem[0] = 32'h24010005;
    sram_mem[32'h41] = 32'h11223344; ref_mem[32'h41] = 32'h11223344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", {31'd0, stall}, 32'd1);
    checkOutput("reset_ce_n", {31'd0, sram_ce_n}, 32'd1);
    checkOutput("reset_oe_n", {31'd0, sram_oe_n}, 32'd1);
    checkOutput("reset_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("reset_be_n", {28'd0, sram_be_n}, 32'hF);
    checkOutput("reset_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    checkOutput("reset_addr", 32'(sram_addr), 32'd0);
    checkOutput("reset_dq_o", sram_dq_o, 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    applyStimulus(32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    checkOutput("fetch_word0", inst, 32'h24010005);

    applyStimulus(32'd0, 32'h104, 32'hAABBCCDD, 4'b0010, 1'b0);
    checkOutput("store_byte1", sram_get(32'h41), 32'h1122CC44);

    applyStimulus(32'd0, 32'h104, 32'd0, 4'd0, 1'b1);
    checkOutput("load_word41", rdata, 32'h1122CC44);

    applyStimulus(32'd0, 32'h104, 32'h12345678, 4'hF, 1'b1);
    checkOutput("conflict_rdata", rdata, 32'h1122CC44);
    checkOutput("conflict_mem", sram_get(32'h41), 32'h12345678);

    applyStimulus(32'hFFF00104, 32'd0, 32'd0, 4'd0, 1'b0);
    checkOutput("alias_fetch", inst, 32'h12345678);

    resetDuringWrite(32'h208, 32'hFFFFFFFF);

    for (int t = 0; t < 150; t++) begin
      logic [3:0] be;
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      applyStimulus(rand_addr(), rand_addr(), $urandom, be, 1'($urandom));
    end

    foreach (ref_mem[a]) checkOutput("final_mem", sram_get(a), ref_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
